// File: rtl/arm_hazard_scoreboard_if.sv
// Hazard-scoreboard port bundle: ID-stage instruction fields and branch input in,
// pipeline control and EXE forwarding selects out.
interface arm_hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic              id_wb_en;
    logic              id_mem_r_en;
    logic [REG_AW-1:0] id_dest;
    logic              branch_taken;
    logic              freeze;
    logic              flush_if;
    logic              bubble_id;
    logic              hazard;
    logic [SEL_W-1:0]  fwd_sel_a;
    logic [SEL_W-1:0]  fwd_sel_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
               branch_taken,
        input  freeze, flush_if, bubble_id, hazard, fwd_sel_a, fwd_sel_b, stall_count
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
               branch_taken,
        output freeze, flush_if, bubble_id, hazard, fwd_sel_a, fwd_sel_b, stall_count
    );
endinterface

// File: rtl/arm_hazard_scoreboard.sv
// Hazard and forwarding controller: a DEPTH-entry shift scoreboard of instructions past ID
// drives freeze/flush/bubble, load-use or RAW stalls, and EXE operand forwarding selects.
module arm_hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int SEL_W  = $clog2(DEPTH),
    parameter int CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst,
    arm_hazard_scoreboard_if.slave sb
);

    generate
        if (DEPTH < 3 || DEPTH > 6) begin : g_bad_depth
            $error("arm_hazard_scoreboard: DEPTH must be in 3..6");
        end
    endgenerate

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              two_src;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             raw;
    logic             haz;
    logic             br;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;

    function automatic logic reg_match(input entry_t e, input logic [REG_AW-1:0] r);
        return e.valid & e.wb_en & (e.dest == r);
    endfunction

    function automatic logic src_hit(input entry_t e, input logic [REG_AW-1:0] s1,
                                     input logic [REG_AW-1:0] s2, input logic two);
        return reg_match(e, s1) | (two & reg_match(e, s2));
    endfunction

    assign br = sb.branch_taken;

    // The WB entry never counts: the register file writes it on the opposite edge.
    always_comb begin
        raw = 1'b0;
        if (FWD_EN != 0) begin
            raw = ent_q[0].mem_r & src_hit(ent_q[0], sb.id_src1, sb.id_src2, sb.id_two_src);
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                raw = raw | src_hit(ent_q[k], sb.id_src1, sb.id_src2, sb.id_two_src);
            end
        end
        haz = sb.id_valid & raw & ~br;
    end

    always_comb begin
        ent_d[0].valid   = sb.id_valid & ~haz & ~br;
        ent_d[0].wb_en   = sb.id_wb_en;
        ent_d[0].mem_r   = sb.id_mem_r_en;
        ent_d[0].dest    = sb.id_dest;
        ent_d[0].src1    = sb.id_src1;
        ent_d[0].src2    = sb.id_src2;
        ent_d[0].two_src = sb.id_two_src;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
        cnt_d = cnt_q;
        if (haz && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Scan from the oldest entry down so the nearest producer overwrites the select last.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        if ((FWD_EN != 0) && ent_q[0].valid) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (reg_match(ent_q[k], ent_q[0].src1)) begin
                    sel_a = SEL_W'(k);
                end
                if (ent_q[0].two_src && reg_match(ent_q[k], ent_q[0].src2)) begin
                    sel_b = SEL_W'(k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k].valid <= 1'b0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb.freeze      = haz;
    assign sb.hazard      = haz;
    assign sb.bubble_id   = haz | br;
    assign sb.flush_if    = br;
    assign sb.fwd_sel_a   = sel_a;
    assign sb.fwd_sel_b   = sel_b;
    assign sb.stall_count = cnt_q;

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Directed bench for arm_hazard_scoreboard: stall-mode, forward-mode and a narrow-counter
// instance share one ID stimulus; each scenario checks the instance it targets.
module tb_arm_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, branch_taken;
    logic [3:0] id_src1, id_src2, id_dest;
    int         n_vec = 0;
    int         n_err = 0;
    int         nfrz;

    always #5 clk = ~clk;

    arm_hazard_scoreboard_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) if_stall ();
    arm_hazard_scoreboard_if #(.REG_AW(4), .SEL_W(2), .CNT_W(16)) if_fwd ();
    arm_hazard_scoreboard_if #(.REG_AW(4), .SEL_W(3), .CNT_W(4))  if_sat ();

    assign if_stall.id_valid = id_valid;    assign if_fwd.id_valid = id_valid;    assign if_sat.id_valid = id_valid;
    assign if_stall.id_src1 = id_src1;      assign if_fwd.id_src1 = id_src1;      assign if_sat.id_src1 = id_src1;
    assign if_stall.id_src2 = id_src2;      assign if_fwd.id_src2 = id_src2;      assign if_sat.id_src2 = id_src2;
    assign if_stall.id_two_src = id_two_src; assign if_fwd.id_two_src = id_two_src; assign if_sat.id_two_src = id_two_src;
    assign if_stall.id_wb_en = id_wb_en;    assign if_fwd.id_wb_en = id_wb_en;    assign if_sat.id_wb_en = id_wb_en;
    assign if_stall.id_mem_r_en = id_mem_r_en; assign if_fwd.id_mem_r_en = id_mem_r_en; assign if_sat.id_mem_r_en = id_mem_r_en;
    assign if_stall.id_dest = id_dest;      assign if_fwd.id_dest = id_dest;      assign if_sat.id_dest = id_dest;
    assign if_stall.branch_taken = branch_taken; assign if_fwd.branch_taken = branch_taken; assign if_sat.branch_taken = branch_taken;

    arm_hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .FWD_EN(0), .SEL_W(2), .CNT_W(16))
        u_stall (.clk(clk), .rst(rst), .sb(if_stall));
    arm_hazard_scoreboard #(.REG_AW(4), .DEPTH(3), .FWD_EN(1), .SEL_W(2), .CNT_W(16))
        u_fwd (.clk(clk), .rst(rst), .sb(if_fwd));
    arm_hazard_scoreboard #(.REG_AW(4), .DEPTH(5), .FWD_EN(0), .SEL_W(3), .CNT_W(4))
        u_sat (.clk(clk), .rst(rst), .sb(if_sat));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic wb, input logic mr, input logic [3:0] d);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_r_en = mr; id_dest = d; branch_taken = 1'b0;
    endtask

    task automatic set_nop;
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
            id_two_src = 1'($urandom); id_wb_en = 1'($urandom); id_mem_r_en = 1'($urandom);
            id_dest = 4'($urandom); branch_taken = 1'($urandom);
            tick;
        end
        rst = 1'b0;
        set_nop;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        set_nop;
        // Reset with random inputs; afterwards a valid ID instruction sees an empty scoreboard.
        do_reset;
        set_id(1'b1, 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1, 4'($urandom));
        settle;
        chk("rst_stall_freeze", 32'(if_stall.freeze), 0);
        chk("rst_stall_flush", 32'(if_stall.flush_if), 0);
        chk("rst_stall_bubble", 32'(if_stall.bubble_id), 0);
        chk("rst_stall_hazard", 32'(if_stall.hazard), 0);
        chk("rst_stall_cnt", 32'(if_stall.stall_count), 0);
        chk("rst_fwd_sel_a", 32'(if_fwd.fwd_sel_a), 0);
        chk("rst_fwd_sel_b", 32'(if_fwd.fwd_sel_b), 0);
        chk("rst_fwd_freeze", 32'(if_fwd.freeze), 0);
        chk("rst_fwd_cnt", 32'(if_fwd.stall_count), 0);
        chk("rst_sat_hazard", 32'(if_sat.hazard), 0);
        chk("rst_sat_cnt", 32'(if_sat.stall_count), 0);
        tick;

        // Stall mode: ADD R1,R2,R3 then SUB R2,R1,R3 -> two stall cycles.
        do_reset;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        settle; chk("stl_add_haz", 32'(if_stall.hazard), 0);
        tick;
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
        settle;
        chk("stl_c1_freeze", 32'(if_stall.freeze), 1);
        chk("stl_c1_bubble", 32'(if_stall.bubble_id), 1);
        chk("stl_c1_hazard", 32'(if_stall.hazard), 1);
        chk("stl_c1_flush", 32'(if_stall.flush_if), 0);
        tick;
        settle;
        chk("stl_c2_freeze", 32'(if_stall.freeze), 1);
        chk("stl_c2_cnt", 32'(if_stall.stall_count), 1);
        tick;
        settle;
        chk("stl_c3_hazard", 32'(if_stall.hazard), 0);
        chk("stl_c3_freeze", 32'(if_stall.freeze), 0);
        chk("stl_c3_cnt", 32'(if_stall.stall_count), 2);
        tick;
        set_nop;
        settle;
        chk("stl_no_fwd", 32'(if_stall.fwd_sel_a), 0);
        chk("stl_cnt_hold", 32'(if_stall.stall_count), 2);
        tick;

        // Reset in the middle of a stall: the re-presented SUB must see no stale hazard.
        do_reset;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        tick;
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
        settle; chk("mid_rst_haz_before", 32'(if_stall.hazard), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        settle;
        chk("mid_rst_haz_after", 32'(if_stall.hazard), 0);
        chk("mid_rst_freeze", 32'(if_stall.freeze), 0);
        chk("mid_rst_cnt", 32'(if_stall.stall_count), 0);
        tick;

        // Forward mode: back-to-back dependency forwards from entry 1, then from entry 2.
        do_reset;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        tick;
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
        settle;
        chk("fwd_b2b_freeze", 32'(if_fwd.freeze), 0);
        chk("fwd_b2b_hazard", 32'(if_fwd.hazard), 0);
        tick;
        set_nop;
        settle;
        chk("fwd_b2b_sel_a", 32'(if_fwd.fwd_sel_a), 1);
        chk("fwd_b2b_sel_b", 32'(if_fwd.fwd_sel_b), 0);
        tick;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd1);
        tick;
        set_id(1'b1, 4'd8, 4'd9, 1'b0, 1'b1, 1'b0, 4'd7);
        tick;
        set_id(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
        settle; chk("fwd_gap_freeze", 32'(if_fwd.freeze), 0);
        tick;
        set_nop;
        settle;
        chk("fwd_gap_sel_a", 32'(if_fwd.fwd_sel_a), 2);
        chk("fwd_gap_sel_b", 32'(if_fwd.fwd_sel_b), 0);
        chk("fwd_gap_cnt", 32'(if_fwd.stall_count), 0);
        tick;

        // Load-use: LDR R4 then ADD R5,R4,R4 stalls once; the load is in WB when ADD reaches EXE.
        do_reset;
        set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4);
        tick;
        set_id(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 4'd5);
        settle;
        chk("lu_c1_freeze", 32'(if_fwd.freeze), 1);
        chk("lu_c1_hazard", 32'(if_fwd.hazard), 1);
        chk("lu_c1_bubble", 32'(if_fwd.bubble_id), 1);
        tick;
        settle;
        chk("lu_c2_freeze", 32'(if_fwd.freeze), 0);
        chk("lu_c2_hazard", 32'(if_fwd.hazard), 0);
        tick;
        set_nop;
        settle;
        chk("lu_sel_a", 32'(if_fwd.fwd_sel_a), 2);
        chk("lu_sel_b", 32'(if_fwd.fwd_sel_b), 2);
        chk("lu_cnt", 32'(if_fwd.stall_count), 1);
        tick;

        // Branch wins over a simultaneous hazard on R15; the dependent never enters EXE.
        do_reset;
        set_id(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0, 4'd15);
        tick;
        set_id(1'b1, 4'd15, 4'd3, 1'b1, 1'b1, 1'b0, 4'd2);
        branch_taken = 1'b1;
        settle;
        chk("br_flush", 32'(if_stall.flush_if), 1);
        chk("br_bubble", 32'(if_stall.bubble_id), 1);
        chk("br_freeze", 32'(if_stall.freeze), 0);
        chk("br_hazard", 32'(if_stall.hazard), 0);
        chk("br_fwd_flush", 32'(if_fwd.flush_if), 1);
        tick;
        set_nop;
        settle;
        chk("br_bubble_sel_a", 32'(if_fwd.fwd_sel_a), 0);
        chk("br_flush_clear", 32'(if_stall.flush_if), 0);
        chk("br_cnt", 32'(if_stall.stall_count), 0);
        tick;

        // Narrow counter, DEPTH=5: a self-dependent chain stalls 4 of every 5 cycles -> 20 stalls.
        do_reset;
        nfrz = 0;
        set_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        for (int c = 0; c < 25; c++) begin
            settle;
            if (if_sat.freeze) nfrz++;
            if (c == 5) chk("sat_mid_cnt", 32'(if_sat.stall_count), 4);
            tick;
        end
        set_nop;
        settle;
        chk("sat_stall_cycles", 32'(nfrz), 20);
        chk("sat_cnt", 32'(if_sat.stall_count), 15);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
